racetrack_shift_ctrl: RTL and testbench

//  Shift sequencer for the racetrack array, directly downstream of the block controller FSM.
//  - Turns the controller's shift enables into a counted train of shift pulses, with a direction.
//  - Returns the level signals shift_done_s / shift_done_r that the FSM waits on in PORT_SET / PORT_RESET.
//  - Saves the set-shift count so that PORT_RESET can move the track back by the same distance.

---
 rtl/racetrack_defines.sv | 21 ++
 rtl/racetrack_pulse_gen.sv | 37 +++
 rtl/racetrack_shift_ctrl.sv | 147 ++++++++++++++
 tb/tb_racetrack_shift_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/racetrack_defines.sv
// Shared definitions for the racetrack array control blocks.
//   shift_state_t      : state encoding of the shift sequencer FSM
//   SHIFT_PULSE_PERIOD : default number of cycles per shift pulse
//   shift_is_active()  : true while a pulse train is running
package racetrack_defines;

  localparam int unsigned SHIFT_PULSE_PERIOD = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_SET,
    S_DONE_SET,
    S_SHIFT_RST,
    S_DONE_RST
  } shift_state_t;

  function automatic logic shift_is_active(input shift_state_t st);
    return (st == S_SHIFT_SET) || (st == S_SHIFT_RST);
  endfunction

endpackage

// File: rtl/racetrack_pulse_gen.sv
// Period counter for the shift pulse train.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   en_i    : run the counter; low holds it at phase 0
//   pulse_o : high on the first cycle of every period while enabled
//   tc_o    : terminal-count strobe, high on the last cycle of every period
module racetrack_pulse_gen
  import racetrack_defines::*;
#(
  parameter int unsigned PULSE_PERIOD = SHIFT_PULSE_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic pulse_o,
  output logic tc_o
);

  // A period of 1 still needs a 1-bit counter so the ports stay legal.
  localparam int unsigned PW = (PULSE_PERIOD > 1) ? $clog2(PULSE_PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(PULSE_PERIOD - 1);

  logic [PW-1:0] phase_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || (phase_q == LAST)) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PW'(1);
    end
  end

  // Gating with en_i means a dropped enable kills the pulse in the same cycle.
  assign pulse_o = en_i && (phase_q == '0);
  assign tc_o    = en_i && (phase_q == LAST);

endmodule

// File: rtl/racetrack_shift_ctrl.sv
// Shift sequencer for the racetrack array. Converts the block controller's
// set/reset shift enables into a counted train of shift pulses with a fixed
// direction, reports completion as level signals, and remembers the set
// distance so a reset shift can return the track by the same amount.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   shift_en_s_i        : set-shift request (level)
//   shift_en_r_i        : reset-shift request (level)
//   shift_s_i           : direction sampled at load (1=left, 0=right)
//   source_shift_sel_i  : reset distance source (1=saved set count, 0=n_shift_i)
//   n_shift_i           : requested distance, sampled at load
//   shift_pulse_o       : shift current pulse
//   shift_dir_o         : registered direction of the train
//   shift_done_s_o      : set shifts complete (level)
//   shift_done_r_o      : reset shifts complete (level)
//   busy_o              : pulse train in progress
//   err_o               : sticky protocol error
module racetrack_shift_ctrl
  import racetrack_defines::*;
#(
  parameter int unsigned CNT_WIDTH    = 10,
  parameter int unsigned PULSE_PERIOD = SHIFT_PULSE_PERIOD
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 shift_en_s_i,
  input  logic                 shift_en_r_i,
  input  logic                 shift_s_i,
  input  logic                 source_shift_sel_i,
  input  logic [CNT_WIDTH-1:0] n_shift_i,
  output logic                 shift_pulse_o,
  output logic                 shift_dir_o,
  output logic                 shift_done_s_o,
  output logic                 shift_done_r_o,
  output logic                 busy_o,
  output logic                 err_o
);

  shift_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_WIDTH-1:0] saved_q, saved_d;
  logic [CNT_WIDTH-1:0] rst_dist;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic                 en_match;
  logic                 pg_en;
  logic                 pg_pulse;
  logic                 pg_tc;

  // The enable that keeps the current state alive.
  always_comb begin
    en_match = 1'b0;
    case (state_q)
      S_SHIFT_SET, S_DONE_SET: en_match = shift_en_s_i;
      S_SHIFT_RST, S_DONE_RST: en_match = shift_en_r_i;
      default:                 en_match = 1'b0;
    endcase
  end

  // Reset and a dropped enable both stop the train without a final pulse.
  assign pg_en = shift_is_active(state_q) && en_match && !rst_i;

  racetrack_pulse_gen #(
    .PULSE_PERIOD(PULSE_PERIOD)
  ) u_pulse_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (pg_en),
    .pulse_o(pg_pulse),
    .tc_o   (pg_tc)
  );

  assign rst_dist = source_shift_sel_i ? saved_q : n_shift_i;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    saved_d = saved_q;
    dir_d   = dir_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (shift_en_s_i) begin
          rem_d   = n_shift_i;
          saved_d = n_shift_i;
          dir_d   = shift_s_i;
          if (shift_en_r_i) begin
            err_d = 1'b1;
          end
          state_d = (n_shift_i != '0) ? S_SHIFT_SET : S_DONE_SET;
        end else if (shift_en_r_i) begin
          rem_d   = rst_dist;
          dir_d   = shift_s_i;
          state_d = (rst_dist != '0) ? S_SHIFT_RST : S_DONE_RST;
        end
      end

      S_SHIFT_SET, S_SHIFT_RST: begin
        if (!en_match) begin
          // Saved count is intentionally left as loaded.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (pg_tc) begin
          // Saturating decrement: the last period lands on zero and stops there.
          if (rem_q <= CNT_WIDTH'(1)) begin
            rem_d   = '0;
            state_d = (state_q == S_SHIFT_SET) ? S_DONE_SET : S_DONE_RST;
          end else begin
            rem_d = rem_q - CNT_WIDTH'(1);
          end
        end
      end

      S_DONE_SET, S_DONE_RST: begin
        if (!en_match) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      saved_q <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      saved_q <= saved_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign shift_pulse_o  = pg_pulse;
  assign shift_dir_o    = dir_q;
  assign shift_done_s_o = (state_q == S_DONE_SET);
  assign shift_done_r_o = (state_q == S_DONE_RST);
  assign busy_o         = shift_is_active(state_q);
  assign err_o          = err_q;

endmodule

// File: tb/tb_racetrack_shift_ctrl.sv
// Testbench for racetrack_shift_ctrl: directed scenarios followed by random
// request sequences, every cycle compared with a timeline-based reference.
module tb_racetrack_shift_ctrl;

  localparam int CW = 10;
  localparam int P  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_s = 1'b0;
  logic          en_r = 1'b0;
  logic          s = 1'b0;
  logic          sel = 1'b0;
  logic [CW-1:0] n = '0;

  logic pulse, dir, done_s, done_r, busy, err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference: a train is described by its first-pulse cycle and length k.
  int ph = 0;  // 0 idle, 1 train running, 2 done reported
  bit m_set = 1'b0;
  int m_start = 0;
  int m_k = 0;
  bit m_dir = 1'b0;
  bit m_err = 1'b0;
  int m_saved = 0;

  int total_pulses = 0;
  int done_s_rise = -1;
  int done_r_rise = -1;
  bit prev_done_s = 1'b0;
  bit prev_done_r = 1'b0;

  racetrack_shift_ctrl #(
    .CNT_WIDTH   (CW),
    .PULSE_PERIOD(P)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .shift_en_s_i      (en_s),
    .shift_en_r_i      (en_r),
    .shift_s_i         (s),
    .source_shift_sel_i(sel),
    .n_shift_i         (n),
    .shift_pulse_o     (pulse),
    .shift_dir_o       (dir),
    .shift_done_s_o    (done_s),
    .shift_done_r_o    (done_r),
    .busy_o            (busy),
    .err_o             (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit ens_m;
    bit ep;
    int el;
    ens_m = m_set ? en_s : en_r;
    el    = cyc - m_start;
    ep    = (ph == 1) && ens_m && !rst && ((el % P) == 0);

    chk("pulse",  32'(pulse),  32'(ep));
    chk("busy",   32'(busy),   32'(ph == 1));
    chk("dir",    32'(dir),    32'(m_dir));
    chk("done_s", 32'(done_s), 32'((ph == 2) && m_set));
    chk("done_r", 32'(done_r), 32'((ph == 2) && !m_set));
    chk("err",    32'(err),    32'(m_err));

    if (pulse === 1'b1) total_pulses++;
    if (done_s === 1'b1 && !prev_done_s) done_s_rise = cyc;
    if (done_r === 1'b1 && !prev_done_r) done_r_rise = cyc;
    prev_done_s = (done_s === 1'b1);
    prev_done_r = (done_r === 1'b1);

    // Advance the reference across the coming clock edge.
    if (rst) begin
      ph = 0; m_dir = 1'b0; m_err = 1'b0; m_saved = 0; m_k = 0;
    end else begin
      case (ph)
        0: begin
          if (en_s) begin
            m_set = 1'b1; m_k = int'(n); m_saved = int'(n); m_dir = s;
            if (en_r) m_err = 1'b1;
            m_start = cyc + 1;
            ph = (m_k != 0) ? 1 : 2;
          end else if (en_r) begin
            m_set = 1'b0; m_k = sel ? m_saved : int'(n); m_dir = s;
            m_start = cyc + 1;
            ph = (m_k != 0) ? 1 : 2;
          end
        end
        1: begin
          if (!ens_m) begin
            ph = 0; m_err = 1'b1;
          end else if (el == m_k * P - 1) begin
            ph = 2;
          end
        end
        default: if (!ens_m) ph = 0;
      endcase
    end
    cyc++;
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en_s = 1'b0; en_r = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    int base;
    wait_cyc(3);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err",  32'(err),  32'd0);

    // 1: set train of 3 pulses, left
    n = 10'd3; s = 1'b1; en_s = 1'b1; t0 = cyc; base = total_pulses;
    wait_cyc(10);
    chk("t1_pulses", 32'(total_pulses - base), 32'd3);
    chk("t1_done_at", 32'(done_s_rise), 32'(t0 + 7));
    chk("t1_done_held", 32'(done_s), 32'd1);
    chk("t1_dir", 32'(dir), 32'd1);
    en_s = 1'b0;
    wait_cyc(2);

    // 2: reset from saved count (3), ignore n=9
    n = 10'd9; s = 1'b0; sel = 1'b1; en_r = 1'b1; t0 = cyc; base = total_pulses;
    wait_cyc(10);
    chk("t2_pulses", 32'(total_pulses - base), 32'd3);
    chk("t2_done_at", 32'(done_r_rise), 32'(t0 + 7));
    chk("t2_dir", 32'(dir), 32'd0);
    en_r = 1'b0;
    wait_cyc(2);

    // 3: zero-distance set and reset
    n = 10'd0; s = 1'b1; en_s = 1'b1; t0 = cyc; base = total_pulses;
    wait_cyc(3);
    chk("t3_done_s_at", 32'(done_s_rise), 32'(t0 + 1));
    en_s = 1'b0;
    wait_cyc(2);
    sel = 1'b0; n = 10'd0; en_r = 1'b1; t0 = cyc;
    wait_cyc(3);
    chk("t3_done_r_at", 32'(done_r_rise), 32'(t0 + 1));
    chk("t3_pulses", 32'(total_pulses - base), 32'd0);
    en_r = 1'b0;
    wait_cyc(2);

    // 4: both enables together, set wins
    n = 10'd2; s = 1'b1; en_s = 1'b1; en_r = 1'b1; t0 = cyc; base = total_pulses;
    wait_cyc(8);
    chk("t4_pulses", 32'(total_pulses - base), 32'd2);
    chk("t4_done_s_at", 32'(done_s_rise), 32'(t0 + 5));
    chk("t4_err", 32'(err), 32'd1);
    en_s = 1'b0; en_r = 1'b0;
    wait_cyc(3);
    chk("t4_err_sticky", 32'(err), 32'd1);

    // 5: enable dropped after second pulse
    do_reset();
    n = 10'd5; s = 1'b0; en_s = 1'b1; t0 = cyc; base = total_pulses;
    wait_cyc(4);
    en_s = 1'b0;
    wait_cyc(1);
    chk("t5_idle", 32'(busy), 32'd0);
    wait_cyc(8);
    chk("t5_pulses", 32'(total_pulses - base), 32'd2);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_no_done", 32'(done_s_rise < t0), 32'd1);

    // 6: reset mid-train clears outputs and the saved count
    do_reset();
    n = 10'd4; s = 1'b1; en_s = 1'b1; t0 = cyc; base = total_pulses;
    wait_cyc(2);
    chk("t6_one_pulse", 32'(total_pulses - base), 32'd1);
    rst = 1'b1; en_s = 1'b0;
    wait_cyc(1);
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_dir",  32'(dir),  32'd0);
    chk("t6_err",  32'(err),  32'd0);
    base = total_pulses;
    n = 10'd7; sel = 1'b1; en_r = 1'b1; t0 = cyc;
    wait_cyc(4);
    chk("t6_rst_pulses", 32'(total_pulses - base), 32'd0);
    chk("t6_done_r_at", 32'(done_r_rise), 32'(t0 + 1));
    en_r = 1'b0;
    wait_cyc(2);

    // Random request sequences, including aborts and both-enable collisions
    for (int i = 0; i < 300; i++) begin
      int kind;
      if ($urandom_range(0, 19) == 0) do_reset();
      n   = CW'($urandom_range(0, 12));
      s   = 1'($urandom);
      sel = 1'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        en_s = 1'b1;
      end else if (kind < 9) begin
        en_r = 1'b1;
      end else begin
        en_s = 1'b1; en_r = 1'b1;
      end
      wait_cyc(int'($urandom_range(1, 30)));
      en_s = 1'b0; en_r = 1'b0;
      wait_cyc(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
